// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_lsu_pkg                                              |
// | Brief    : Shared types and lane constants for the dmem load/store   |
// |            unit. S_ERR exists only when MISALIGN_TRAP_EN is defined. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package dmem_lsu_pkg;

    localparam int c_BYTE_W = 8;
    localparam int c_HALF_W = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_RD  = 3'd1,
        S_LD_RSP = 3'd2,
        S_ST_WR  = 3'd3,
        S_RMW_RD = 3'd4,
`ifdef MISALIGN_TRAP_EN
        S_RMW_WR = 3'd5,
        S_ERR    = 3'd6
`else
        S_RMW_WR = 3'd5
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lsu_lane_align                                            |
// | Brief    : Combinational load lane extract/extend and store lane     |
// |            merge for a 32-bit word without byte enables.             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module lsu_lane_align
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            i_size,
    input  logic [1:0]            i_off,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_mem_word,
    input  logic [c_HALF_W-1:0]   i_store_lane,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic [DATA_WIDTH-1:0] o_merged_word
);

    logic [c_BYTE_W-1:0] w_byte;
    logic [c_HALF_W-1:0] w_half;

    // Half lanes use only off[1], so a misaligned half falls back to its aligned lane.
    assign w_byte = i_mem_word[{i_off, 3'b000} +: c_BYTE_W];
    assign w_half = i_mem_word[{i_off[1], 4'b0000} +: c_HALF_W];

    always_comb begin
        o_load_data   = i_mem_word;
        o_merged_word = i_mem_word;
        if (i_size == SZ_BYTE) begin
            o_load_data = {{(DATA_WIDTH-c_BYTE_W){~i_unsigned & w_byte[c_BYTE_W-1]}}, w_byte};
            o_merged_word[{i_off, 3'b000} +: c_BYTE_W] = i_store_lane[c_BYTE_W-1:0];
        end else if (i_size == SZ_HALF) begin
            o_load_data = {{(DATA_WIDTH-c_HALF_W){~i_unsigned & w_half[c_HALF_W-1]}}, w_half};
            o_merged_word[{i_off[1], 4'b0000} +: c_HALF_W] = i_store_lane;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_lsu                                                  |
// | Brief    : Load/store unit driving a word-addressed dmem with 1-cycle|
// |            registered read; sub-word stores use read-modify-write.   |
// |            Define MISALIGN_TRAP_EN to trap misaligned half/word.     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [1:0]                   req_size,
    input  logic                         req_unsigned,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [DATA_WIDTH-1:0]        req_wdata,
    output logic                         resp_valid,
    output logic [DATA_WIDTH-1:0]        resp_rdata,
    output logic                         resp_err,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_write_data,
    output logic                         mem_write,
    output logic                         mem_read,
    input  logic [DATA_WIDTH-1:0]        mem_dout
);

    localparam int c_IDX_W = $clog2(MEM_DEPTH);

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [c_IDX_W-1:0]    r_idx;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_accept;
    logic                  w_sub_word;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_merged_word;
    logic                  w_unused_addr;

    // Address bits above the word index wrap and are deliberately dropped.
    assign w_unused_addr = ^req_addr[ADDR_WIDTH-1:c_IDX_W+2];

    assign w_accept   = req_valid && req_ready;
    assign w_sub_word = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (!w_sub_word && (req_addr[1:0] != 2'b00));
`endif

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_idx      <= '0;
            r_off      <= 2'b00;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_idx      <= req_addr[2 +: c_IDX_W];
            r_off      <= req_addr[1:0];
            r_wdata    <= req_wdata;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef MISALIGN_TRAP_EN
                    if (w_misalign)
                        w_next = S_ERR;
                    else
`endif
                    if (!req_we)
                        w_next = S_LD_RD;
                    else if (w_sub_word)
                        w_next = S_RMW_RD;
                    else
                        w_next = S_ST_WR;
                end
            end
            S_LD_RD:  w_next = S_LD_RSP;
            S_RMW_RD: w_next = S_RMW_WR;
            default:  w_next = S_IDLE;
        endcase
    end

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .i_size        (r_size),
        .i_off         (r_off),
        .i_unsigned    (r_unsigned),
        .i_mem_word    (mem_dout),
        .i_store_lane  (r_wdata[c_HALF_W-1:0]),
        .o_load_data   (w_load_data),
        .o_merged_word (w_merged_word)
    );

    // Everything is masked during RESET so an in-flight RMW write is dropped silently.
    always_comb begin
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (!RESET) begin
            req_ready = (r_state == S_IDLE);
            if (r_state != S_IDLE)
                mem_addr = r_idx;
            case (r_state)
                S_LD_RD, S_RMW_RD: mem_read = 1'b1;
                S_LD_RSP: begin
                    resp_valid = 1'b1;
                    resp_rdata = w_load_data;
                end
                S_ST_WR: begin
                    mem_write      = 1'b1;
                    mem_write_data = r_wdata;
                    resp_valid     = 1'b1;
                end
                S_RMW_WR: begin
                    mem_write      = 1'b1;
                    mem_write_data = w_merged_word;
                    resp_valid     = 1'b1;
                end
`ifdef MISALIGN_TRAP_EN
                S_ERR: resp_valid = 1'b1;
`endif
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign resp_err = !RESET && (r_state == S_ERR);
`else
    assign resp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_lsu                                               |
// | Brief    : Directed self-checking bench for dmem_lsu with a simple   |
// |            registered-read dmem model. Honors MISALIGN_TRAP_EN.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_write_data;
        if (mem_read)  mem_dout      <= mem[mem_addr];
    end

    dmem_lsu u_dut (
        .clk            (clk),
        .RESET          (RESET),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_dout       (mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request; watches up to 4 cycles after accept for the response.
    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output logic saw_rd, output logic saw_wr, output logic [9:0] wr_addr);
        logic both;
        lat = 0; rdata = '0; err = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0; wr_addr = '0; both = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 4 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) both = 1'b1;
            if (mem_read) saw_rd = 1'b1;
            if (mem_write) begin
                saw_wr  = 1'b1;
                wr_addr = mem_addr;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
            end
        end
        check("rd_wr_exclusive", {31'b0, both}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
        int lat; logic [31:0] rd; logic err, srd, swr; logic [9:0] wa;
        txn(1'b0, size, uns, addr, 32'h0, lat, rd, err, srd, swr, wa);
        check({tag, "_lat"}, lat, 32'd2);
        check({tag, "_rdata"}, rd, exp);
        check({tag, "_nowrite"}, {31'b0, swr}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int idx, input logic [31:0] exp_word);
        int lat; logic [31:0] rd; logic err, srd, swr; logic [9:0] wa;
        logic sub;
        sub = (size == 2'b00) || (size == 2'b01);
        txn(1'b1, size, 1'b0, addr, wdata, lat, rd, err, srd, swr, wa);
        check({tag, "_lat"}, lat, sub ? 32'd2 : 32'd1);
        check({tag, "_read"}, {31'b0, srd}, {31'b0, sub});
        check({tag, "_write"}, {31'b0, swr}, 32'd1);
        check({tag, "_waddr"}, {22'b0, wa}, idx);
        check({tag, "_rdata0"}, rd, 32'h0);
        @(posedge clk);
        #1 check({tag, "_memword"}, mem[idx], exp_word);
    endtask

    initial begin
        int lat; logic [31:0] rd; logic err, srd, swr; logic [9:0] wa;
        RESET = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        RESET = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        // Word store/load round trip
        do_store("st_w_dead", 2'b10, 32'h10, 32'hDEADBEEF, 4, 32'hDEADBEEF);
        do_load ("ld_w_dead", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

        // Byte RMW and lane loads
        do_store("st_w_init", 2'b10, 32'h10, 32'h11223344, 4, 32'h11223344);
        do_store("st_b_a5",   2'b00, 32'h11, 32'hFFFFFFA5, 4, 32'h1122A544);
        do_load ("ld_b_s",    2'b00, 1'b0, 32'h11, 32'hFFFFFFA5);
        do_load ("ld_b_u",    2'b00, 1'b1, 32'h11, 32'h000000A5);
        do_load ("ld_h_s",    2'b01, 1'b0, 32'h12, 32'h00001122);

        // Half RMW
        do_store("st_h_8001", 2'b01, 32'h12, 32'h00008001, 4, 32'h8001A544);
        do_load ("ld_h_s2",   2'b01, 1'b0, 32'h12, 32'hFFFF8001);
        do_load ("ld_h_u2",   2'b01, 1'b1, 32'h12, 32'h00008001);
        do_load ("ld_b3_u",   2'b00, 1'b1, 32'h13, 32'h00000080);
        do_load ("ld_b0_s",   2'b00, 1'b0, 32'h10, 32'h00000044);

        // Size 11 acts as word; upper address bits wrap
        do_store("st_sz3",    2'b11, 32'h14, 32'hCAFEF00D, 5, 32'hCAFEF00D);
        do_load ("ld_wrap",   2'b10, 1'b0, 32'h1014, 32'hCAFEF00D);

        // Reset during RMW_RD drops the write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rd_read", {31'b0, mem_read}, 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_mid_rw", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("rst_mid_rw2", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_mid_resp2", {31'b0, resp_valid}, 32'd0);
        RESET = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        check("rst_mid_nowrite", {31'b0, mem_write}, 32'd0);
        check("rst_mid_noresp", {31'b0, resp_valid}, 32'd0);
        check("rst_mid_memword", mem[4], 32'h8001A544);

        // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
        txn(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, rd, err, srd, swr, wa);
        check("mis_h_lat", lat, 32'd1);
        check("mis_h_err", {31'b0, err}, 32'd1);
        check("mis_h_rdata", rd, 32'h0);
        check("mis_h_noread", {31'b0, srd}, 32'd0);
        txn(1'b1, 2'b10, 1'b0, 32'h11, 32'h12345678, lat, rd, err, srd, swr, wa);
        check("mis_w_lat", lat, 32'd1);
        check("mis_w_err", {31'b0, err}, 32'd1);
        check("mis_w_nowrite", {31'b0, swr}, 32'd0);
        @(posedge clk);
        #1 check("mis_w_memword", mem[4], 32'h8001A544);
`else
        txn(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, rd, err, srd, swr, wa);
        check("mis_h_lat", lat, 32'd2);
        check("mis_h_err", {31'b0, err}, 32'd0);
        check("mis_h_rdata", rd, 32'hFFFF8001);
        check("mis_h_read", {31'b0, srd}, 32'd1);
        do_load("mis_w", 2'b10, 1'b0, 32'h11, 32'h8001A544);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit that is the requesting side of the synchronous data memory (dmem) port. It takes byte-addressed byte/half/word load and store requests from the core over a valid/ready handshake. It drives the dmem word-addressed interface, which has no byte enables, and returns sign- or zero-extended load data. Sub-word stores use a read-modify-write sequence against dmem's 1-cycle registered read.

Parameters:
DATA_WIDTH, 32, data word width (fixed 32 for lane logic)
MEM_DEPTH, 1024, dmem depth in words
ADDR_WIDTH, 32, core byte-address width

Ports:
clk  in  1  clock, all state on posedge
RESET  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  extended load data; 0 when not a load response
resp_err  out  1  misaligned-access error (tied 0 without feature)
mem_addr  out  $clog2(MEM_DEPTH)  dmem word index
mem_write_data  out  DATA_WIDTH  dmem write data
mem_write  out  1  dmem write enable
mem_read  out  1  dmem read enable
mem_dout  in  DATA_WIDTH  dmem registered read data

Behaviour:
- Clock and reset: one clock, clk; RESET is synchronous and active-high.
- Request latch:
  - Handshake fires on req_valid && req_ready. All req_* fields are latched into registers.
  - req_valid while busy is ignored; the requester holds the request.
- Addressing:
  - word index = req_addr[2 +: $clog2(MEM_DEPTH)]. Upper bits are ignored, so addresses wrap.
  - off = req_addr[1:0].
- FSM states: IDLE, LD_RD, LD_RSP, ST_WR, RMW_RD, RMW_WR, ERR.
  - IDLE: accept. Load goes to LD_RD. Word store goes to ST_WR. Byte/half store goes to RMW_RD.
  - LD_RD: mem_read=1. Next state LD_RSP.
  - LD_RSP: mem_dout is valid. resp_valid=1 and resp_rdata = extracted lane, extended. Next state IDLE.
  - ST_WR: mem_write=1, mem_write_data = latched wdata, resp_valid=1. Next state IDLE.
  - RMW_RD: mem_read=1. Next state RMW_WR.
  - RMW_WR: mem_write=1, mem_write_data = mem_dout with the target lane replaced, resp_valid=1. Next state IDLE.
- Latency after the accept cycle:
  - load: 2 cycles
  - word store: 1 cycle
  - sub-word store: 2 cycles
- Output generation:
  - mem_* outputs are combinational from state and latched registers only; there is no req_* to mem_* path.
  - mem_addr = latched index in every non-IDLE state, 0 in IDLE.
  - mem_read and mem_write are never asserted together.
- Lanes:
  - byte lane = off; data = bits [8*off +: 8].
  - half lane = off[1]; data = bits [16*off[1] +: 16].
  - Stores replace only the lane, from req_wdata[7:0] or req_wdata[15:0].
- Misalignment without feature: half ignores off[0]; word ignores off[1:0].
- Reset:
  - state = IDLE; latched registers = 0.
  - resp_valid, resp_err, resp_rdata, mem_* outputs = 0.
  - While RESET is high, mem_read and mem_write are forced 0. A pending write is dropped and no resp_valid is produced.
  - req_ready = 1 in the first cycle after RESET deasserts.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a half access with off[0]=1, or a word access with off!=0, goes IDLE -> ERR. ERR produces no mem access; resp_valid=1, resp_err=1, resp_rdata=0 one cycle after accept, then IDLE.
- Undefined: the ERR state is absent, resp_err is tied 0, and the offset bits are truncated as described under Behaviour.

Decomposition:
- Package dmem_lsu_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state_t enum
  - lane width constants
- Sub-module lsu_lane_align (combinational):
  - load extract plus sign/zero extend
  - store lane merge
  - unit-testable on its own

Test Plan:
1. Store word 0xDEADBEEF @0x10, then load word @0x10 -> mem_addr=4, mem_write in the 1st cycle after accept; load resp_rdata=0xDEADBEEF in the 2nd cycle after accept.
2. Word 4 = 0x11223344; store byte 0xA5 @0x11 -> mem_read then mem_write; dmem word = 0x1122A544; resp_valid in the 2nd cycle.
3. Load byte @0x11 signed -> 0xFFFFFFA5; unsigned -> 0x000000A5. Load half @0x12 signed -> 0x00001122.
4. Store half 0x8001 @0x12 -> word 0x8001A544; load half @0x12 signed -> 0xFFFF8001, unsigned -> 0x00008001.
5. RESET high in the RMW_RD cycle of a byte store -> no mem_write, no resp_valid, dmem word unchanged, req_ready=1 after release.
6. Half load @0x13. With MISALIGN_TRAP_EN -> resp_err=1 one cycle after accept, mem_read never asserted. Without it -> same result as a load @0x12.
